// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I control path and its ALU.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR, S_MEM_RD, S_MEM_WB,
    S_MEM_WR, S_BRANCH, S_JAL, S_JALR, S_JALR_T, S_JUMP_PC, S_LUI, S_HALT
  } state_t;

  // Which decode table the ALU decoder applies to funct3/funct7_5.
  typedef enum logic [1:0] {AC_ADD, AC_R, AC_I, AC_BR} alu_class_t;

  // ALU operation codes, shared with the ALU.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps (alu_class, funct3, funct7_5) to an ALU op code and an unsupported-funct3 flag.
// Latency: purely combinational.
// Backpressure: none.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_class,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_op,
  output logic       illegal_f3
);

  // Decode table; shifts and unassigned branch funct3 values are flagged.
  always_comb begin
    alu_op     = ALU_ADD;
    illegal_f3 = 1'b0;
    case (alu_class)
      AC_R, AC_I: begin
        case (funct3)
          3'b000:  alu_op = (alu_class == AC_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          default: illegal_f3 = 1'b1;
        endcase
      end
      AC_BR: begin
        case (funct3)
          3'b000, 3'b001: alu_op = ALU_SUB;
          3'b100, 3'b101: alu_op = ALU_SLT;
          3'b110, 3'b111: alu_op = ALU_SLTU;
          default:        illegal_f3 = 1'b1;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I datapath: fetch/decode/execute/memory/writeback sequencing.
// Latency: 3-5 states per instruction plus memory wait cycles; outputs decoded from state and IR fields.
// Backpressure: FETCH, MEM_RD and MEM_WR hold with a steady request until mem_ready.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  result_src,
  output logic [2:0]  imm_src,
  output logic        illegal,
  output logic [31:0] retired
);

  state_t     state, state_nxt;
  alu_class_t alu_class;
  logic [2:0] dec_op;
  logic       dec_ill;
  logic [31:0] wait_cnt;
  logic       timeout;
  logic       taken;

  // Timeout fires on the cycle that would be the FETCH_TIMEOUT-th unanswered fetch cycle.
  assign timeout = (FETCH_TIMEOUT > 0) && (wait_cnt == 32'(FETCH_TIMEOUT - 1));
  // beq/bge/bgeu take on zero; bne/blt/bltu take on !zero.
  assign taken   = zero ^ (funct3[2] ? ~funct3[0] : funct3[0]);

  // Select the ALU decode table for the current state.
  always_comb begin
    case (state)
      S_EXEC_R: alu_class = AC_R;
      S_EXEC_I: alu_class = AC_I;
      S_BRANCH: alu_class = AC_BR;
      default:  alu_class = AC_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_class  (alu_class),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .alu_op     (dec_op),
    .illegal_f3 (dec_ill)
  );

  // Next state and control outputs; everything stays zero while reset is asserted.
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            state_nxt  = S_DECODE;
          end else if (timeout) begin
            state_nxt = S_HALT;
          end
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_B;
          case (op)
            OP_R:               state_nxt = S_EXEC_R;
            OP_I:               state_nxt = S_EXEC_I;
            OP_LOAD, OP_STORE:  state_nxt = S_MEM_ADDR;
            OP_BRANCH:          state_nxt = S_BRANCH;
            OP_JAL:             state_nxt = S_JAL;
            OP_JALR:            state_nxt = S_JALR;
            OP_LUI:             state_nxt = S_LUI;
            default:            state_nxt = S_HALT;
          endcase
        end
        S_EXEC_R, S_EXEC_I: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = (state == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
          alu_op    = dec_op;
          state_nxt = dec_ill ? S_HALT : S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          state_nxt = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
          state_nxt = (op == OP_STORE) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) state_nxt = S_MEM_WB;
        end
        S_MEM_WB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (mem_ready) state_nxt = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = SRCA_RS1;
          imm_src   = IMM_B;
          alu_op    = dec_op;
          if (dec_ill) begin
            state_nxt = S_HALT;
          end else begin
            pc_write  = taken;
            state_nxt = S_FETCH;
          end
        end
        S_JAL, S_JALR: begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          reg_write  = 1'b1;
          imm_src    = IMM_J;
          state_nxt  = (state == S_JAL) ? S_JUMP_PC : S_JALR_T;
        end
        S_JUMP_PC: begin
          pc_write  = 1'b1;
          state_nxt = S_FETCH;
        end
        S_JALR_T: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_IMM;
          result_src = RES_ALU;
          pc_write   = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_LUI: begin
          imm_src    = IMM_U;
          result_src = RES_IMM;
          reg_write  = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_HALT;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Count consecutive unanswered fetch cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           wait_cnt <= '0;
    else if (state == S_FETCH && !mem_ready) wait_cnt <= wait_cnt + 32'd1;
    else                                  wait_cnt <= '0;
  end

  // Sticky illegal flag and retired-instruction counter (last cycle = return to FETCH).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      if (state_nxt == S_HALT) illegal <= 1'b1;
      if (state != S_FETCH && state_nxt == S_FETCH) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with a per-cycle expectation scoreboard.
// Latency: expectations are pushed as each cycle's stimulus is driven and popped at the falling edge.
// Backpressure: mem_ready stalls are driven explicitly by the stimulus sequence.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5, zero, mem_ready;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_op, imm_src;
  logic        illegal;
  logic [31:0] retired;

  typedef struct packed {
    logic req, wr, adr, irw, pcw, rgw;
    logic [1:0] sa, sb;
    logic [2:0] aop;
    logic [1:0] rs;
    logic [2:0] imm;
    logic ill;
  } ctl_t;

  typedef struct packed { ctl_t e; ctl_t m; } exp_t;
  typedef struct { string tag; ctl_t e; ctl_t m; logic [31:0] ret; } sb_t;

  sb_t         sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_ret;
  ctl_t        obs;

  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal};

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .imm_src(imm_src), .illegal(illegal), .retired(retired)
  );

  // Expected-output builders: strobes and illegal are always checked, selects only where defined.
  function automatic exp_t x_base();
    exp_t x;
    x.e = '0; x.m = '0;
    x.m.req = 1'b1; x.m.wr = 1'b1; x.m.irw = 1'b1; x.m.pcw = 1'b1; x.m.rgw = 1'b1; x.m.ill = 1'b1;
    return x;
  endfunction

  function automatic exp_t x_reset();
    exp_t x;
    x.e = '0; x.m = '1;
    return x;
  endfunction

  function automatic exp_t x_fetch(input logic rdy);
    exp_t x = x_base();
    x.e.req = 1'b1; x.m.adr = 1'b1;
    if (rdy) begin
      x.e.irw = 1'b1; x.e.pcw = 1'b1;
      x.m.sa = '1; x.e.sa = 2'b00; x.m.sb = '1; x.e.sb = 2'b10;
      x.m.aop = '1; x.e.aop = 3'b000; x.m.rs = '1; x.e.rs = 2'b10;
    end
    return x;
  endfunction

  function automatic exp_t x_decode();
    exp_t x = x_base();
    x.m.sa = '1; x.e.sa = 2'b01; x.m.sb = '1; x.e.sb = 2'b01;
    x.m.aop = '1; x.e.aop = 3'b000; x.m.imm = '1; x.e.imm = 3'b010;
    return x;
  endfunction

  function automatic exp_t x_exec(input logic isr, input logic [2:0] aop, input logic chk);
    exp_t x = x_base();
    x.m.sa = '1; x.e.sa = 2'b10; x.m.sb = '1; x.e.sb = isr ? 2'b00 : 2'b01;
    if (chk) begin x.m.aop = '1; x.e.aop = aop; end
    return x;
  endfunction

  function automatic exp_t x_wb(input logic [1:0] rs);
    exp_t x = x_base();
    x.e.rgw = 1'b1; x.m.rs = '1; x.e.rs = rs;
    return x;
  endfunction

  function automatic exp_t x_maddr(input logic store);
    exp_t x = x_base();
    x.m.sa = '1; x.e.sa = 2'b10; x.m.sb = '1; x.e.sb = 2'b01;
    x.m.aop = '1; x.e.aop = 3'b000; x.m.imm = '1; x.e.imm = store ? 3'b001 : 3'b000;
    return x;
  endfunction

  function automatic exp_t x_mem(input logic wr);
    exp_t x = x_base();
    x.e.req = 1'b1; x.e.wr = wr; x.m.adr = 1'b1; x.e.adr = 1'b1;
    return x;
  endfunction

  function automatic exp_t x_branch(input logic [2:0] aop, input logic tk);
    exp_t x = x_base();
    x.m.sa = '1; x.e.sa = 2'b10; x.m.sb = '1; x.e.sb = 2'b00;
    x.m.rs = '1; x.e.rs = 2'b00; x.m.aop = '1; x.e.aop = aop; x.e.pcw = tk;
    return x;
  endfunction

  function automatic exp_t x_jal();
    exp_t x = x_base();
    x.m.sa = '1; x.e.sa = 2'b01; x.m.sb = '1; x.e.sb = 2'b10; x.m.aop = '1; x.e.aop = 3'b000;
    x.m.rs = '1; x.e.rs = 2'b10; x.e.rgw = 1'b1; x.m.imm = '1; x.e.imm = 3'b011;
    return x;
  endfunction

  function automatic exp_t x_jump();
    exp_t x = x_base();
    x.m.rs = '1; x.e.rs = 2'b00; x.e.pcw = 1'b1;
    return x;
  endfunction

  function automatic exp_t x_lui();
    exp_t x = x_base();
    x.m.imm = '1; x.e.imm = 3'b100; x.m.rs = '1; x.e.rs = 2'b11; x.e.rgw = 1'b1;
    return x;
  endfunction

  function automatic exp_t x_halt();
    exp_t x = x_base();
    x.e.ill = 1'b1;
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // One clock cycle: push the expectation, compare at the falling edge, return just after the rising edge.
  task automatic step(input string tag, input exp_t x);
    sb_t r;
    sb_q.push_back('{tag, x.e, x.m, exp_ret});
    @(negedge clk);
    r = sb_q.pop_front();
    check(r.tag, 32'(obs & r.m), 32'(r.e & r.m));
    check({r.tag, "/retired"}, retired, r.ret);
    @(posedge clk); #1;
  endtask

  task automatic do_fetch(input int waits, input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7_5 = f7; mem_ready = 1'b0;
    for (int i = 0; i < waits; i++) step("fetch_wait", x_fetch(1'b0));
    mem_ready = 1'b1;
    step("fetch_rdy", x_fetch(1'b1));
    mem_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    exp_ret = '0;
    step("reset", x_reset());
    rst_n = 1'b1;
  endtask

  logic [2:0] r_f3  [6] = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010, 3'b011};
  logic       r_f7  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [2:0] r_aop [6] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b100, 3'b101};

  initial begin
    op = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    rst_n = 1'b0; exp_ret = '0;
    @(posedge clk); #1;
    step("reset", x_reset());
    rst_n = 1'b1;

    // add x3,x1,x2 with a two-cycle fetch stall
    do_fetch(2, 7'b0110011, 3'b000, 1'b0);
    step("decode_add", x_decode());
    step("exec_add", x_exec(1'b1, 3'b000, 1'b1));
    step("wb_add", x_wb(2'b00));
    exp_ret = exp_ret + 1;

    // sub, and, or, xor, slt, sltu
    for (int i = 0; i < 6; i++) begin
      do_fetch(0, 7'b0110011, r_f3[i], r_f7[i]);
      step("decode_r", x_decode());
      step($sformatf("exec_r%0d", i), x_exec(1'b1, r_aop[i], 1'b1));
      step("wb_r", x_wb(2'b00));
      exp_ret = exp_ret + 1;
    end

    // addi-form slt immediate
    do_fetch(0, 7'b0010011, 3'b010, 1'b1);
    step("decode_i", x_decode());
    step("exec_slti", x_exec(1'b0, 3'b100, 1'b1));
    step("wb_i", x_wb(2'b00));
    exp_ret = exp_ret + 1;

    // beq taken, bge not taken
    do_fetch(0, 7'b1100011, 3'b000, 1'b0);
    step("decode_beq", x_decode());
    zero = 1'b1;
    step("branch_beq", x_branch(3'b001, 1'b1));
    exp_ret = exp_ret + 1;
    do_fetch(0, 7'b1100011, 3'b101, 1'b0);
    step("decode_bge", x_decode());
    zero = 1'b0;
    step("branch_bge", x_branch(3'b100, 1'b0));
    exp_ret = exp_ret + 1;

    // lw with a four-cycle memory stall
    do_fetch(1, 7'b0000011, 3'b010, 1'b0);
    step("decode_lw", x_decode());
    step("maddr_lw", x_maddr(1'b0));
    for (int i = 0; i < 4; i++) step("mem_rd_wait", x_mem(1'b0));
    mem_ready = 1'b1;
    step("mem_rd_rdy", x_mem(1'b0));
    mem_ready = 1'b0;
    step("mem_wb", x_wb(2'b01));
    exp_ret = exp_ret + 1;

    // sw with a four-cycle memory stall
    do_fetch(0, 7'b0100011, 3'b010, 1'b0);
    step("decode_sw", x_decode());
    step("maddr_sw", x_maddr(1'b1));
    for (int i = 0; i < 4; i++) step("mem_wr_wait", x_mem(1'b1));
    mem_ready = 1'b1;
    step("mem_wr_rdy", x_mem(1'b1));
    mem_ready = 1'b0;
    exp_ret = exp_ret + 1;

    // jal, then lui
    do_fetch(0, 7'b1101111, 3'b000, 1'b0);
    step("decode_jal", x_decode());
    step("jal_link", x_jal());
    step("jump_pc", x_jump());
    exp_ret = exp_ret + 1;
    do_fetch(0, 7'b0110111, 3'b000, 1'b0);
    step("decode_lui", x_decode());
    step("lui", x_lui());
    exp_ret = exp_ret + 1;

    // unsupported opcode (fence) halts until reset, even with mem_ready high
    do_fetch(0, 7'b0001111, 3'b000, 1'b0);
    step("decode_fence", x_decode());
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step("halt_fence", x_halt());
    mem_ready = 1'b0;
    pulse_reset();

    // sll is unsupported
    do_fetch(0, 7'b0110011, 3'b001, 1'b0);
    step("decode_sll", x_decode());
    step("exec_sll", x_exec(1'b1, 3'b000, 1'b0));
    for (int i = 0; i < 3; i++) step("halt_sll", x_halt());
    pulse_reset();

    // one retired instruction, then reset during a store wait
    do_fetch(0, 7'b0110111, 3'b000, 1'b0);
    step("decode_lui2", x_decode());
    step("lui2", x_lui());
    exp_ret = exp_ret + 1;
    do_fetch(0, 7'b0100011, 3'b000, 1'b0);
    step("decode_sw2", x_decode());
    step("maddr_sw2", x_maddr(1'b1));
    step("mem_wr_wait2", x_mem(1'b1));
    #1;
    check("mem_req_before_rst", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mem_req_async_drop", 32'(mem_req), 32'd0);
    check("mem_write_async_drop", 32'(mem_write), 32'd0);
    check("retired_async_clear", retired, 32'd0);
    exp_ret = '0;
    @(posedge clk); #1;
    step("reset_mid_wr", x_reset());
    rst_n = 1'b1;
    step("fetch_after_rst", x_fetch(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
